// File: rtl/dds_key_ctrl.sv
// DDS front-panel key controller: edits freq/wave/amp settings and offers each committed set atomically over valid/ready.
// Optional hold-to-repeat on the up/down keys is built only when AUTO_REPEAT_EN is defined.
module dds_key_ctrl #(
  parameter int unsigned      FW_W    = 32,
  parameter logic [FW_W-1:0]  F_DEF   = 32'd85899,
  parameter logic [FW_W-1:0]  F_STEP  = 32'd8590,
  parameter logic [FW_W-1:0]  F_MIN   = 32'd8590,
  parameter logic [FW_W-1:0]  F_MAX   = 32'd858993459,
  parameter int unsigned      REP_DLY = 25_000_000,
  parameter int unsigned      REP_PER = 5_000_000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            key_mode,
  input  logic            key_up,
  input  logic            key_down,
  input  logic            up_held,
  input  logic            down_held,
  input  logic            cfg_ready,
  output logic            cfg_valid,
  output logic [FW_W-1:0] cfg_freq,
  output logic [1:0]      cfg_wave,
  output logic [2:0]      cfg_amp,
  output logic [1:0]      edit_field
);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_LOAD, S_WAIT} state_t;

  state_t          state, state_nxt;
  logic [FW_W-1:0] edit_freq;
  logic [1:0]      edit_wave;
  logic [2:0]      edit_amp;
  logic            dirty;
  logic            up_tick, dn_tick;

`ifdef AUTO_REPEAT_EN
  localparam int unsigned CW = $clog2(REP_DLY + 1);
  logic [CW-1:0] up_cnt, dn_cnt;
  logic          up_only, dn_only;

  assign up_only = up_held & ~down_held;
  assign dn_only = down_held & ~up_held;
  assign up_tick = up_only && (up_cnt == CW'(REP_DLY - 1));
  assign dn_tick = dn_only && (dn_cnt == CW'(REP_DLY - 1));

  // After the first tick the counter is rewound so later ticks land every REP_PER cycles.
  always_ff @(posedge clk) begin
    if (rst || !up_only) up_cnt <= '0;
    else if (up_tick)    up_cnt <= CW'(REP_DLY - REP_PER);
    else                 up_cnt <= up_cnt + 1'b1;
    if (rst || !dn_only) dn_cnt <= '0;
    else if (dn_tick)    dn_cnt <= CW'(REP_DLY - REP_PER);
    else                 dn_cnt <= dn_cnt + 1'b1;
  end
`else
  logic unused_held;
  assign unused_held = up_held | down_held | (REP_DLY == REP_PER);
  assign up_tick = 1'b0;
  assign dn_tick = 1'b0;
`endif

  logic            up_evt, dn_evt, step_up, step_dn, step;
  logic [FW_W:0]   f_sum, f_dif;
  logic [FW_W-1:0] freq_inc, freq_dec;

  assign up_evt  = key_up | up_tick;
  assign dn_evt  = key_down | dn_tick;
  assign step_up = up_evt & ~dn_evt;
  assign step_dn = dn_evt & ~up_evt;
  assign step    = step_up | step_dn;

  // One extra bit so the increment cannot wrap before the saturation compare.
  always_comb begin
    f_sum    = {1'b0, edit_freq} + {1'b0, F_STEP};
    f_dif    = {1'b0, edit_freq} - {1'b0, F_STEP};
    freq_inc = (f_sum > {1'b0, F_MAX}) ? F_MAX : f_sum[FW_W-1:0];
    freq_dec = (f_dif[FW_W] || (f_dif[FW_W-1:0] < F_MIN)) ? F_MIN : f_dif[FW_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_INIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT: state_nxt = S_LOAD;
      S_IDLE: if (dirty) state_nxt = S_LOAD;
      S_LOAD: state_nxt = S_WAIT;
      S_WAIT: if (cfg_ready) state_nxt = dirty ? S_LOAD : S_IDLE;
      default: state_nxt = S_INIT;
    endcase
  end

  assign cfg_valid = (state == S_WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      edit_field <= 2'd0;
      edit_freq  <= F_DEF;
      edit_wave  <= 2'd0;
      edit_amp   <= 3'd7;
      dirty      <= 1'b0;
      cfg_freq   <= F_DEF;
      cfg_wave   <= 2'd0;
      cfg_amp    <= 3'd7;
    end else begin
      // A step always lands on the field that was selected before any key_mode this cycle.
      if (step) begin
        case (edit_field)
          2'd0: edit_freq <= step_up ? freq_inc : freq_dec;
          2'd1: edit_wave <= step_up ? edit_wave + 2'd1 : edit_wave - 2'd1;
          2'd2: begin
            if (step_up && edit_amp != 3'd7)      edit_amp <= edit_amp + 3'd1;
            else if (step_dn && edit_amp != 3'd0) edit_amp <= edit_amp - 3'd1;
          end
          default: ;
        endcase
      end
      if (key_mode) edit_field <= (edit_field == 2'd2) ? 2'd0 : edit_field + 2'd1;
      if (step)                 dirty <= 1'b1;
      else if (state == S_LOAD) dirty <= 1'b0;
      if (state == S_LOAD) begin
        cfg_freq <= edit_freq;
        cfg_wave <= edit_wave;
        cfg_amp  <= edit_amp;
      end
    end
  end

endmodule

// File: tb/tb_dds_key_ctrl.sv
// Directed + randomized bench for dds_key_ctrl against a plain-arithmetic settings model.
module tb_dds_key_ctrl;
  localparam logic [31:0] F_DEF  = 32'd85899;
  localparam logic [31:0] F_STEP = 32'd8590;
  localparam logic [31:0] F_MIN  = 32'd8590;
  localparam logic [31:0] F_MAX  = 32'd257700;
`ifdef AUTO_REPEAT_EN
  localparam int EXP_REP = 4;
`else
  localparam int EXP_REP = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_mode = 1'b0, key_up = 1'b0, key_down = 1'b0;
  logic        up_held = 1'b0, down_held = 1'b0;
  logic        cfg_ready = 1'b1;
  logic        cfg_valid;
  logic [31:0] cfg_freq;
  logic [1:0]  cfg_wave;
  logic [2:0]  cfg_amp;
  logic [1:0]  edit_field;

  dds_key_ctrl #(
    .FW_W(32), .F_DEF(F_DEF), .F_STEP(F_STEP), .F_MIN(F_MIN), .F_MAX(F_MAX),
    .REP_DLY(20), .REP_PER(5)
  ) dut (
    .clk(clk), .rst(rst), .key_mode(key_mode), .key_up(key_up), .key_down(key_down),
    .up_held(up_held), .down_held(down_held), .cfg_ready(cfg_ready),
    .cfg_valid(cfg_valid), .cfg_freq(cfg_freq), .cfg_wave(cfg_wave), .cfg_amp(cfg_amp),
    .edit_field(edit_field)
  );

  always #10 clk = ~clk;

  int tests = 0;
  int fails = 0;

  longint m_freq;
  int     m_wave, m_amp, m_field;

  int          hs_cnt = 0;
  logic [31:0] hs_f;
  logic [1:0]  hs_w;
  logic [2:0]  hs_a;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_freq = F_DEF; m_wave = 0; m_amp = 7; m_field = 0;
  endfunction

  function automatic void model_apply(input bit up, input bit dn, input bit mode);
    if (up != dn) begin
      case (m_field)
        0: begin
          m_freq = up ? m_freq + F_STEP : m_freq - F_STEP;
          if (m_freq > F_MAX) m_freq = F_MAX;
          if (m_freq < F_MIN) m_freq = F_MIN;
        end
        1: m_wave = (m_wave + (up ? 1 : 3)) % 4;
        default: begin
          m_amp = up ? m_amp + 1 : m_amp - 1;
          if (m_amp > 7) m_amp = 7;
          if (m_amp < 0) m_amp = 0;
        end
      endcase
    end
    if (mode) m_field = (m_field + 1) % 3;
  endfunction

  // One clock: drive pulses, advance, sample at the falling edge, track handshakes and stalls.
  task automatic step(input bit up, input bit dn, input bit mode);
    logic        pv, pr, prst;
    logic [31:0] pf;
    logic [1:0]  pw;
    logic [2:0]  pa;
    key_up = up; key_down = dn; key_mode = mode;
    pv = cfg_valid; pr = cfg_ready; prst = rst;
    pf = cfg_freq; pw = cfg_wave; pa = cfg_amp;
    if (rst) model_reset();
    else     model_apply(up, dn, mode);
    @(posedge clk);
    @(negedge clk);
    key_up = 1'b0; key_down = 1'b0; key_mode = 1'b0;
    if (!prst && pv && pr) begin
      hs_cnt++; hs_f = pf; hs_w = pw; hs_a = pa;
    end else if (!prst && pv) begin
      chk("stall_valid", cfg_valid, 1);
      chk("stall_freq", cfg_freq, pf);
      chk("stall_wave_amp", {cfg_wave, cfg_amp}, {pw, pa});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  initial begin
    int h0;
    model_reset();
    @(negedge clk);
    idle(2);
    chk("rst_valid", cfg_valid, 0);
    chk("rst_freq", cfg_freq, F_DEF);
    chk("rst_wave", cfg_wave, 0);
    chk("rst_amp", cfg_amp, 7);
    chk("rst_field", edit_field, 0);

    rst = 1'b0;
    idle(1);
    chk("boot_c1_valid", cfg_valid, 0);
    idle(1);
    chk("boot_c2_valid", cfg_valid, 1);
    chk("boot_c2_freq", cfg_freq, 85899);
    idle(1);
    chk("boot_c3_valid", cfg_valid, 0);
    chk("boot_hs_cnt", hs_cnt, 1);

    step(1, 0, 0);
    chk("lat_n1_valid", cfg_valid, 0);
    idle(1);
    chk("lat_n2_valid", cfg_valid, 0);
    idle(1);
    chk("lat_n3_valid", cfg_valid, 1);
    chk("lat_n3_freq", cfg_freq, 94489);
    idle(7);
    chk("up1_hs_freq", hs_f, 94489);
    step(1, 0, 0); idle(9);
    chk("up2_hs_freq", hs_f, 103079);
    step(1, 0, 0); idle(9);
    chk("up3_hs_freq", hs_f, 111669);
    chk("up3_hs_cnt", hs_cnt, 4);

    step(0, 0, 1);
    chk("field_wave", edit_field, 1);
    step(0, 1, 0); idle(8);
    chk("wave_wrap", hs_w, 3);
    h0 = hs_cnt;
    step(0, 0, 1);
    step(1, 0, 0); idle(8);
    chk("amp_sat_hs", hs_cnt, h0 + 1);
    chk("amp_sat_val", hs_a, 7);
    step(0, 0, 1);
    chk("field_wrap", edit_field, 0);

    cfg_ready = 1'b0;
    step(1, 0, 0); idle(5);
    chk("mid_valid", cfg_valid, 1);
    chk("mid_freq", cfg_freq, m_freq);
    rst = 1'b1;
    step(0, 0, 0);
    chk("mid_rst_valid", cfg_valid, 0);
    chk("mid_rst_freq", cfg_freq, F_DEF);
    rst = 1'b0;
    idle(2);
    step(1, 0, 0); idle(9);
    step(1, 0, 0); idle(38);
    chk("stall_end_valid", cfg_valid, 1);
    chk("stall_end_freq", cfg_freq, F_DEF);
    h0 = hs_cnt;
    cfg_ready = 1'b1;
    idle(8);
    chk("stall_rel_hs", hs_cnt, h0 + 2);
    chk("stall_rel_freq", hs_f, F_DEF + 2 * F_STEP);

    h0 = hs_cnt;
    step(1, 1, 0); idle(8);
    chk("both_no_hs", hs_cnt, h0);
    chk("both_valid", cfg_valid, 0);

    while (m_freq < F_MAX - 1) step(1, 0, 0);
    idle(8);
    chk("fmax_m1", hs_f, F_MAX - 1);
    step(1, 0, 0); idle(8);
    chk("fmax_hit", hs_f, F_MAX);
    h0 = hs_cnt;
    step(1, 0, 0); idle(8);
    chk("fmax_sat_hs", hs_cnt, h0 + 1);
    chk("fmax_sat_val", hs_f, F_MAX);
    for (int i = 0; i < 40; i++) step(0, 1, 0);
    idle(8);
    chk("fmin_sat", hs_f, F_MIN);

    rst = 1'b1; step(0, 0, 0); rst = 1'b0;
    idle(4);
    up_held = 1'b1; idle(36); up_held = 1'b0;
    idle(10);
    for (int i = 0; i < EXP_REP; i++) model_apply(1, 0, 0);
    chk("rep_freq", hs_f, F_DEF + EXP_REP * F_STEP);
    chk("rep_model", hs_f, m_freq);

    for (int i = 0; i < 600; i++) begin
      int r;
      r = int'($urandom_range(0, 7));
      cfg_ready = ($urandom_range(0, 3) != 0);
      step(r == 1 || r == 2 || r == 5, r == 3 || r == 4 || r == 5, $urandom_range(0, 7) == 0);
    end
    cfg_ready = 1'b1;
    idle(10);
    chk("rnd_freq", hs_f, m_freq);
    chk("rnd_wave", hs_w, m_wave);
    chk("rnd_amp", hs_a, m_amp);
    chk("rnd_field", edit_field, m_field);
    chk("rnd_valid", cfg_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dds_key_ctrl.md
Name: dds_key_ctrl

Overview:
Front-panel controller for the DDS signal generator. It takes debounced single-cycle key pulses and stable-held levels from the per-key debouncers and keeps the editable generator settings: frequency tuning word, waveform select and amplitude select. It pushes each committed setting set to the DDS core through a valid/ready handshake, so the core only ever sees coherent, atomic updates.

Parameters:
FW_W, 32, tuning word width
F_DEF, 32'd85899, reset tuning word (~1 kHz @ 50 MHz)
F_STEP, 32'd8590, tuning word increment per up/down step
F_MIN, 32'd8590, lowest legal tuning word
F_MAX, 32'd858993459, highest legal tuning word
REP_DLY, 25_000_000, hold cycles before auto-repeat starts (500 ms)
REP_PER, 5_000_000, cycles between auto-repeat steps (100 ms)

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  synchronous reset, active-high
key_mode  in  1  debounced press pulse; advances the edit field
key_up  in  1  debounced press pulse; increment
key_down  in  1  debounced press pulse; decrement
up_held  in  1  debounced stable-pressed level for the up key
down_held  in  1  debounced stable-pressed level for the down key
cfg_ready  in  1  DDS core accepts the configuration
cfg_valid  out  1  configuration offered
cfg_freq  out  FW_W  tuning word
cfg_wave  out  2  0=sine, 1=square, 2=triangle, 3=sawtooth
cfg_amp  out  3  amplitude code, 0 (min) to 7 (full scale)
edit_field  out  2  0=FREQ, 1=WAVE, 2=AMP; drives the display

Behaviour:
- Interface: one clock, `clk`. Reset `rst` is synchronous and active-high, sampled on the rising edge of `clk`.
- While `rst` is high: edit_field=0, edit regs = {F_DEF, 0, 7}, cfg_freq=F_DEF, cfg_wave=0, cfg_amp=7, cfg_valid=0, dirty=0, repeat counters=0, FSM=INIT.
- FSM states:
  - INIT: entered on reset. Next cycle goes to LOAD, so the defaults are offered once.
  - IDLE: cfg_valid=0. If dirty=1, go to LOAD.
  - LOAD (1 cycle): copy edit regs to cfg_* outputs, clear dirty, go to WAIT.
  - WAIT: cfg_valid=1; cfg_* held stable. On cfg_ready=1: cfg_valid drops the next cycle; go to IDLE if dirty=0, else go to LOAD.
- key_mode: edit_field cycles 0→1→2→0. It does not set dirty.
- Step event = key_up or key_down pulse, or an auto-repeat tick.
- Step rules by edit_field:
  - FREQ: edit_freq ± F_STEP, saturating at F_MIN/F_MAX. Compute in FW_W+1 bits so the sum cannot overflow.
  - WAVE: ±1, wrapping modulo 4.
  - AMP: ±1, saturating at 0 and 7.
- Any step event sets dirty, even if the value saturated and did not change.
- Up and down step events in the same cycle: both ignored, no dirty.
- key_mode and a step event in the same cycle: the step applies to the old field; the field advances afterwards.
- Step events in WAIT or LOAD update the edit regs and set dirty. cfg_* never change while cfg_valid=1.
- Latency: with cfg_ready tied high, a step pulse at cycle N gives the edit reg at N+1, dirty at N+1, LOAD at N+2, and cfg_valid=1 with new values at N+3.
- A reset mid-handshake drops cfg_valid immediately and restarts from INIT.

Optional Feature:
AUTO_REPEAT_EN. When defined:
- A per-direction hold counter runs while up_held=1 (or down_held=1) and the other level is 0.
- When the counter reaches REP_DLY, it emits one repeat tick, then a further tick every REP_PER cycles.
- The counter clears when the level drops or both levels are high.
When not defined: up_held and down_held are ignored, with no counters synthesised, and only pulses cause steps.

Test Plan:
- Reset release, cfg_ready=1 → cfg_valid=1 for one cycle at the 2nd cycle after release, with freq=85899, wave=0, amp=7.
- edit_field=FREQ, 3 key_up pulses 10 cycles apart → three handshakes with cfg_freq = 94489, 103079, 111669.
- key_mode ×1, then key_down at wave=0 → cfg_wave=3 (wrap). Then key_mode, and key_up at amp=7 → a handshake still occurs and cfg_amp stays 7.
- cfg_ready=0 held 50 cycles during WAIT, with 2 key_up pulses in FREQ → cfg_* stay constant. After ready, a second handshake carries F_DEF+2·F_STEP.
- key_up and key_down in the same cycle → no dirty and no cfg_valid. Setting edit_freq to F_MAX−1 then key_up → cfg_freq = F_MAX.
- AUTO_REPEAT_EN with REP_DLY=20 and REP_PER=5, up_held high 36 cycles → ticks at hold cycles 20, 25, 30, 35 (4 steps). Without the macro → 0 steps.
